// File: rtl/alu_decode_queue_if.sv
// Handshake bundle for alu_decode_queue.
//   master : upstream/downstream side (drives in_valid/in_instr/in_pc/out_ready)
//   slave  : the queue (drives in_ready, head fields and count)
// Ports carried:
//   in_valid/in_ready/in_instr/in_pc        instruction push side
//   out_valid/out_ready                     head handshake
//   out_alucontrol/out_instr/out_pc/out_ri  head entry fields
//   count                                   occupancy, clog2(DEPTH)+1 bits
interface alu_decode_queue_if #(
    parameter int DEPTH   = 4,
    parameter int ALUOP_W = 8,
    parameter int PC_W    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [ALUOP_W-1:0] out_alucontrol;
    logic [31:0]        out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_ri;
    logic [CW-1:0]      count;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alucontrol, out_instr, out_pc, out_ri, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alucontrol, out_instr, out_pc, out_ri, count
    );
endinterface

// File: rtl/alu_decode_queue.sv
// alu_decode_queue: decodes MIPS instruction words to ALU control codes and
// buffers {alucontrol, ri, instr, pc} in a DEPTH-entry FIFO.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   flush   synchronous discard of all entries (beats push/pop)
//   q       alu_decode_queue_if.slave handshake bundle
// Decode is combinational on q.in_instr and written on push, so a push into
// an empty queue is visible at the head right after that edge.
module alu_decode_queue #(
    parameter int DEPTH   = 4,
    parameter int ALUOP_W = 8,
    parameter int PC_W    = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    alu_decode_queue_if.slave   q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] EXE_NOP_OP     = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP     = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP      = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP     = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP     = 8'b00100111;
    localparam logic [7:0] EXE_ANDI_OP    = 8'b01011001;
    localparam logic [7:0] EXE_ORI_OP     = 8'b01011010;
    localparam logic [7:0] EXE_XORI_OP    = 8'b01011011;
    localparam logic [7:0] EXE_LUI_OP     = 8'b01011100;
    localparam logic [7:0] EXE_SLL_OP     = 8'b01111100;
    localparam logic [7:0] EXE_SLLV_OP    = 8'b00000100;
    localparam logic [7:0] EXE_SRL_OP     = 8'b00000010;
    localparam logic [7:0] EXE_SRLV_OP    = 8'b00000110;
    localparam logic [7:0] EXE_SRA_OP     = 8'b00000011;
    localparam logic [7:0] EXE_SRAV_OP    = 8'b00000111;
    localparam logic [7:0] EXE_MOVZ_OP    = 8'b00001010;
    localparam logic [7:0] EXE_MOVN_OP    = 8'b00001011;
    localparam logic [7:0] EXE_MFHI_OP    = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP    = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP    = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP    = 8'b00010011;
    localparam logic [7:0] EXE_SLT_OP     = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP    = 8'b00101011;
    localparam logic [7:0] EXE_SLTI_OP    = 8'b01010111;
    localparam logic [7:0] EXE_SLTIU_OP   = 8'b01011000;
    localparam logic [7:0] EXE_ADD_OP     = 8'b00100000;
    localparam logic [7:0] EXE_ADDU_OP    = 8'b00100001;
    localparam logic [7:0] EXE_SUB_OP     = 8'b00100010;
    localparam logic [7:0] EXE_SUBU_OP    = 8'b00100011;
    localparam logic [7:0] EXE_ADDI_OP    = 8'b01010101;
    localparam logic [7:0] EXE_ADDIU_OP   = 8'b01010110;
    localparam logic [7:0] EXE_MULT_OP    = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP   = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP     = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP    = 8'b00011011;
    localparam logic [7:0] EXE_J_OP       = 8'b01001111;
    localparam logic [7:0] EXE_JAL_OP     = 8'b01010000;
    localparam logic [7:0] EXE_JALR_OP    = 8'b00001001;
    localparam logic [7:0] EXE_JR_OP      = 8'b00001000;
    localparam logic [7:0] EXE_BEQ_OP     = 8'b01010001;
    localparam logic [7:0] EXE_BNE_OP     = 8'b01010010;
    localparam logic [7:0] EXE_BLEZ_OP    = 8'b01010011;
    localparam logic [7:0] EXE_BGTZ_OP    = 8'b01010100;
    localparam logic [7:0] EXE_BLTZ_OP    = 8'b01000000;
    localparam logic [7:0] EXE_BGEZ_OP    = 8'b01000001;
    localparam logic [7:0] EXE_BLTZAL_OP  = 8'b01001010;
    localparam logic [7:0] EXE_BGEZAL_OP  = 8'b01001011;
    localparam logic [7:0] EXE_LB_OP      = 8'b11100000;
    localparam logic [7:0] EXE_LH_OP      = 8'b11100001;
    localparam logic [7:0] EXE_LW_OP      = 8'b11100011;
    localparam logic [7:0] EXE_LBU_OP     = 8'b11100100;
    localparam logic [7:0] EXE_LHU_OP     = 8'b11100101;
    localparam logic [7:0] EXE_SB_OP      = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP      = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP      = 8'b11101011;
    localparam logic [7:0] EXE_SYSCALL_OP = 8'b00001100;
    localparam logic [7:0] EXE_BREAK_OP   = 8'b00001101;
    localparam logic [7:0] EXE_TGE_OP     = 8'b00110000;
    localparam logic [7:0] EXE_TGEU_OP    = 8'b00110001;
    localparam logic [7:0] EXE_TLT_OP     = 8'b00110010;
    localparam logic [7:0] EXE_TLTU_OP    = 8'b00110011;
    localparam logic [7:0] EXE_TEQ_OP     = 8'b00110100;
    localparam logic [7:0] EXE_TNE_OP     = 8'b00110110;
    localparam logic [7:0] EXE_MFC0_OP    = 8'b01011101;
    localparam logic [7:0] EXE_MTC0_OP    = 8'b01100000;
    localparam logic [7:0] EXE_ERET_OP    = 8'b01101011;

    // Decode of the incoming word.
    logic [5:0] op, funct;
    logic [4:0] rs, rt;
    logic [7:0] dec_op;
    logic       dec_ri;

    assign op    = q.in_instr[31:26];
    assign rs    = q.in_instr[25:21];
    assign rt    = q.in_instr[20:16];
    assign funct = q.in_instr[5:0];

    always_comb begin
        dec_op = EXE_NOP_OP;
        dec_ri = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b000000: dec_op = EXE_SLL_OP;
                    6'b000010: dec_op = EXE_SRL_OP;
                    6'b000011: dec_op = EXE_SRA_OP;
                    6'b000100: dec_op = EXE_SLLV_OP;
                    6'b000110: dec_op = EXE_SRLV_OP;
                    6'b000111: dec_op = EXE_SRAV_OP;
                    6'b001000: dec_op = EXE_JR_OP;
                    6'b001001: dec_op = EXE_JALR_OP;
                    6'b001010: dec_op = EXE_MOVZ_OP;
                    6'b001011: dec_op = EXE_MOVN_OP;
                    6'b001100: dec_op = EXE_SYSCALL_OP;
                    6'b001101: dec_op = EXE_BREAK_OP;
                    6'b010000: dec_op = EXE_MFHI_OP;
                    6'b010001: dec_op = EXE_MTHI_OP;
                    6'b010010: dec_op = EXE_MFLO_OP;
                    6'b010011: dec_op = EXE_MTLO_OP;
                    6'b011000: dec_op = EXE_MULT_OP;
                    6'b011001: dec_op = EXE_MULTU_OP;
                    6'b011010: dec_op = EXE_DIV_OP;
                    6'b011011: dec_op = EXE_DIVU_OP;
                    6'b100000: dec_op = EXE_ADD_OP;
                    6'b100001: dec_op = EXE_ADDU_OP;
                    6'b100010: dec_op = EXE_SUB_OP;
                    6'b100011: dec_op = EXE_SUBU_OP;
                    6'b100100: dec_op = EXE_AND_OP;
                    6'b100101: dec_op = EXE_OR_OP;
                    6'b100110: dec_op = EXE_XOR_OP;
                    6'b100111: dec_op = EXE_NOR_OP;
                    6'b101010: dec_op = EXE_SLT_OP;
                    6'b101011: dec_op = EXE_SLTU_OP;
                    6'b110000: dec_op = EXE_TGE_OP;
                    6'b110001: dec_op = EXE_TGEU_OP;
                    6'b110010: dec_op = EXE_TLT_OP;
                    6'b110011: dec_op = EXE_TLTU_OP;
                    6'b110100: dec_op = EXE_TEQ_OP;
                    6'b110110: dec_op = EXE_TNE_OP;
                    default:   dec_ri = 1'b1;
                endcase
            end
            6'b000001: begin
                case (rt)
                    5'b00000: dec_op = EXE_BLTZ_OP;
                    5'b00001: dec_op = EXE_BGEZ_OP;
                    5'b10000: dec_op = EXE_BLTZAL_OP;
                    5'b10001: dec_op = EXE_BGEZAL_OP;
                    default:  dec_ri = 1'b1;
                endcase
            end
            6'b010000: begin
                if (rs == 5'b00000)
                    dec_op = EXE_MFC0_OP;
                else if (rs == 5'b00100)
                    dec_op = EXE_MTC0_OP;
                else if (rs == 5'b10000 && funct == 6'b011000)
                    dec_op = EXE_ERET_OP;
                else
                    dec_ri = 1'b1;
            end
            6'b000010: dec_op = EXE_J_OP;
            6'b000011: dec_op = EXE_JAL_OP;
            6'b000100: dec_op = EXE_BEQ_OP;
            6'b000101: dec_op = EXE_BNE_OP;
            6'b000110: dec_op = EXE_BLEZ_OP;
            6'b000111: dec_op = EXE_BGTZ_OP;
            6'b001000: dec_op = EXE_ADDI_OP;
            6'b001001: dec_op = EXE_ADDIU_OP;
            6'b001010: dec_op = EXE_SLTI_OP;
            6'b001011: dec_op = EXE_SLTIU_OP;
            6'b001100: dec_op = EXE_ANDI_OP;
            6'b001101: dec_op = EXE_ORI_OP;
            6'b001110: dec_op = EXE_XORI_OP;
            6'b001111: dec_op = EXE_LUI_OP;
            6'b100000: dec_op = EXE_LB_OP;
            6'b100001: dec_op = EXE_LH_OP;
            6'b100011: dec_op = EXE_LW_OP;
            6'b100100: dec_op = EXE_LBU_OP;
            6'b100101: dec_op = EXE_LHU_OP;
            6'b101000: dec_op = EXE_SB_OP;
            6'b101001: dec_op = EXE_SH_OP;
            6'b101011: dec_op = EXE_SW_OP;
            default:   dec_ri = 1'b1;
        endcase
    end

    // FIFO storage and control.
    logic [ALUOP_W-1:0] mem_alu   [DEPTH];
    logic               mem_ri    [DEPTH];
    logic [31:0]        mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count_r;
    logic               push, pop;

    assign q.in_ready  = (count_r != CW'(DEPTH));
    assign q.out_valid = (count_r != '0);
    assign push        = q.in_valid & q.in_ready;
    assign pop         = q.out_valid & q.out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_r   <= '0;
            mem_alu   <= '{default: ALUOP_W'(EXE_NOP_OP)};
            mem_ri    <= '{default: 1'b0};
            mem_instr <= '{default: '0};
            mem_pc    <= '{default: '0};
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                mem_alu[wr_ptr]   <= ALUOP_W'(dec_op);
                mem_ri[wr_ptr]    <= dec_ri;
                mem_instr[wr_ptr] <= q.in_instr;
                mem_pc[wr_ptr]    <= q.in_pc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head fields read straight from the slot at rd_ptr; they hold while
    // the head is not popped.
    assign q.out_alucontrol = mem_alu[rd_ptr];
    assign q.out_ri         = mem_ri[rd_ptr];
    assign q.out_instr      = mem_instr[rd_ptr];
    assign q.out_pc         = mem_pc[rd_ptr];
    assign q.count          = count_r;
endmodule

// File: tb/tb_alu_decode_queue.sv
// Directed bench for alu_decode_queue: reset, decode vectors, backpressure,
// streaming wrap, flush and asynchronous reset.
module tb_alu_decode_queue;
    localparam int DEPTH   = 4;
    localparam int ALUOP_W = 8;
    localparam int PC_W    = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    alu_decode_queue_if #(.DEPTH(DEPTH), .ALUOP_W(ALUOP_W), .PC_W(PC_W)) bus ();

    alu_decode_queue #(.DEPTH(DEPTH), .ALUOP_W(ALUOP_W), .PC_W(PC_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .q      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    // Decode vectors: instruction, expected ALU code, expected ri.
    localparam int NV = 11;
    logic [31:0] dv_instr [NV] = '{32'h04110003, 32'h04000003, 32'h40086000, 32'h42000018,
                                   32'hFC000000, 32'h0000003F, 32'h34210001, 32'h8C220004,
                                   32'h40886000, 32'h42000000, 32'h04030000};
    logic [7:0]  dv_op    [NV] = '{8'h4B, 8'h40, 8'h5D, 8'h6B,
                                   8'h00, 8'h00, 8'h5A, 8'hE3,
                                   8'h60, 8'h00, 8'h00};
    logic        dv_ri    [NV] = '{1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b1, 1'b0, 1'b0,
                                   1'b0, 1'b1, 1'b1};

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_alu", 64'(bus.out_alucontrol), 64'h00);
        check("rst_instr", 64'(bus.out_instr), 64'd0);
        check("rst_pc", 64'(bus.out_pc), 64'd0);
        check("rst_ri", 64'(bus.out_ri), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Single push with head hold.
        push(32'h00851020, 32'h0000_1000);
        check("add_valid", 64'(bus.out_valid), 64'd1);
        check("add_alu", 64'(bus.out_alucontrol), 64'h20);
        check("add_ri", 64'(bus.out_ri), 64'd0);
        check("add_count", 64'(bus.count), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("add_hold_alu", 64'(bus.out_alucontrol), 64'h20);
            check("add_hold_instr", 64'(bus.out_instr), 64'h00851020);
            check("add_hold_pc", 64'(bus.out_pc), 64'h1000);
        end
        pop();
        check("add_pop_valid", 64'(bus.out_valid), 64'd0);

        // REGIMM/COP0: push four, then pop in order.
        for (int i = 0; i < 4; i++)
            push(dv_instr[i], 32'h2000 + 32'(i * 4));
        check("four_count", 64'(bus.count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("four_alu", 64'(bus.out_alucontrol), 64'(dv_op[i]));
            check("four_pc", 64'(bus.out_pc), 64'h2000 + 64'(i * 4));
            pop();
        end
        check("four_empty", 64'(bus.count), 64'd0);

        // Remaining decode vectors one at a time.
        for (int i = 4; i < NV; i++) begin
            push(dv_instr[i], 32'h3000 + 32'(i));
            check("dec_alu", 64'(bus.out_alucontrol), 64'(dv_op[i]));
            check("dec_ri", 64'(bus.out_ri), 64'(dv_ri[i]));
            check("dec_instr", 64'(bus.out_instr), 64'(dv_instr[i]));
            pop();
        end

        // Full and backpressure: five back-to-back pushes, out_ready low.
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.in_instr = 32'h00000021 | (32'(k) << 11);
            bus.in_pc    = 32'h4000 + 32'(k);
            check("full_in_ready", 64'(bus.in_ready), (k < 4) ? 64'd1 : 64'd0);
            if (k < 4) step();
        end
        check("full_count", 64'(bus.count), 64'd4);
        bus.out_ready = 1'b1;
        check("full_head_pc", 64'(bus.out_pc), 64'h4000);
        step();
        bus.out_ready = 1'b0;
        check("full_pop_count", 64'(bus.count), 64'd3);
        check("full_ready_back", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("full_fifth_in", 64'(bus.count), 64'd4);
        for (int k = 1; k < 5; k++) begin
            check("full_drain_pc", 64'(bus.out_pc), 64'h4000 + 64'(k));
            check("full_drain_alu", 64'(bus.out_alucontrol), 64'h21);
            pop();
        end
        check("full_drained", 64'(bus.count), 64'd0);

        // Streaming push/pop with pointer wrap.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 32'h00851020;
            bus.in_pc    = 32'h5000 + 32'(i);
            if (i > 0) begin
                check("strm_pc", 64'(bus.out_pc), 64'h5000 + 64'(i - 1));
                check("strm_count", 64'(bus.count), 64'd1);
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("strm_last_pc", 64'(bus.out_pc), 64'h5009);
        step();
        bus.out_ready = 1'b0;
        check("strm_empty", 64'(bus.count), 64'd0);

        // Flush beats a same-cycle push.
        for (int i = 0; i < 3; i++)
            push(32'h00851020, 32'h6000 + 32'(i));
        check("fl_count3", 64'(bus.count), 64'd3);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h34210001;
        bus.in_pc    = 32'h6100;
        flush        = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_count", 64'(bus.count), 64'd0);
        check("fl_valid", 64'(bus.out_valid), 64'd0);
        check("fl_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("fl_lost", 64'(bus.count), 64'd0);
        push(32'h8C220004, 32'h6200);
        check("fl_new_pc", 64'(bus.out_pc), 64'h6200);
        check("fl_new_alu", 64'(bus.out_alucontrol), 64'hE3);

        // Asynchronous reset between edges.
        push(32'h00851020, 32'h7000);
        check("ar_pre_count", 64'(bus.count), 64'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_valid", 64'(bus.out_valid), 64'd0);
        check("ar_count", 64'(bus.count), 64'd0);
        check("ar_ready", 64'(bus.in_ready), 64'd1);
        check("ar_pc", 64'(bus.out_pc), 64'd0);
        #3;
        resetn = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
